// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse-cipher controller: mode encoding,
// round counts per key size and the sequencer state encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128  = 2'b00,
    AES192  = 2'b01,
    AES256  = 2'b10,
    ILLEGAL = 2'b11
  } aes_mode_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WORD,
    S_CAPT,
    S_LAST,
    S_DONE
  } ctrl_state_e;

  function automatic logic [3:0] nr_of_mode(input aes_mode_e m);
    case (m)
      AES192:  return NR_192;
      AES256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_round_ctrl.sv
// Round sequencer for the iterative AES inverse-cipher datapath: four word
// cycles plus one capture cycle per round, then a final add-round-key cycle.
// Optional abort input enabled by defining AES_INV_CTRL_ABORT_EN.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int MSW_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_INV_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         err,
  output logic [3:0]   dp_round,
  output logic [1:0]   dp_mode,
  output logic [2:0]   dp_width_sel,
  output logic [127:0] dp_data_in,
  input  logic [127:0] dp_data_out,
  output logic [3:0]   key_idx,
  output logic         busy
);

  ctrl_state_e  fsm_q, fsm_d;
  aes_mode_e    mode_q;
  logic [127:0] data_q;
  logic [127:0] out_q;
  logic [3:0]   round_q;
  logic [3:0]   nr;
  logic [1:0]   word_q;
  logic [1:0]   word_sel;
  logic [2:0]   wsel_q;
  logic         err_q;
  logic         accept;
  logic         legal;
  logic         abort_hit;

`ifdef AES_INV_CTRL_ABORT_EN
  assign abort_hit = abort & (fsm_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign nr       = nr_of_mode(mode_q);
  assign accept   = in_valid & (fsm_q == S_IDLE);
  assign legal    = aes_mode_e'(in_mode) != ILLEGAL;
  // Descending order 3,2,1,0 is simply the bitwise complement of the count.
  assign word_sel = (MSW_FIRST != 0) ? ~word_q : word_q;

  assign in_ready     = (fsm_q == S_IDLE);
  assign busy         = (fsm_q != S_IDLE);
  assign out_valid    = (fsm_q == S_DONE);
  assign out_data     = out_q;
  assign err          = err_q;
  assign dp_round     = round_q;
  assign dp_mode      = mode_q;
  assign dp_data_in   = data_q;
  assign dp_width_sel = (fsm_q == S_WORD) ? {1'b0, word_sel} : wsel_q;
  assign key_idx      = (fsm_q == S_IDLE) ? 4'd0 : nr - round_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= S_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (accept && legal) fsm_d = S_WORD;
      S_WORD:  if (word_q == 2'd3) fsm_d = S_CAPT;
      S_CAPT:  fsm_d = (round_q == nr - 4'd1) ? S_LAST : S_WORD;
      S_LAST:  fsm_d = S_DONE;
      S_DONE:  if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
    if (abort_hit) fsm_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      out_q   <= '0;
      mode_q  <= AES128;
      round_q <= '0;
      word_q  <= '0;
      wsel_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // Illegal-mode requests are consumed by the handshake and only flagged.
      err_q <= accept & ~legal;
      if (!abort_hit) begin
        case (fsm_q)
          S_IDLE: begin
            if (accept && legal) begin
              data_q  <= in_data;
              mode_q  <= aes_mode_e'(in_mode);
              round_q <= '0;
              word_q  <= '0;
            end
          end
          S_WORD: begin
            wsel_q <= {1'b0, word_sel};
            word_q <= word_q + 2'd1;
          end
          S_CAPT: begin
            // On the last round this lands on Nr, which the final cycle needs.
            data_q  <= dp_data_out;
            round_q <= round_q + 4'd1;
          end
          S_LAST:  out_q <= dp_data_out;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: an AES inverse-round datapath and key store are
// modelled here, and a transaction-level model predicts the controller outputs.
module tb_aes_inv_round_ctrl;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_mode = 2'b00;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         err;
  logic [3:0]   dp_round;
  logic [1:0]   dp_mode;
  logic [2:0]   dp_width_sel;
  logic [127:0] dp_data_in;
  logic [127:0] dp_data_out = '0;
  logic [3:0]   key_idx;
  logic         busy;
`ifdef AES_INV_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic         b_in_ready, b_out_valid, b_err, b_busy;
  logic [127:0] b_out_data, b_dp_data_in;
  logic [127:0] b_dp_data_out = '0;
  logic [3:0]   b_dp_round, b_key_idx;
  logic [1:0]   b_dp_mode;
  logic [2:0]   b_dp_width_sel;

  aes_inv_round_ctrl #(.MSW_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err),
    .dp_round(dp_round), .dp_mode(dp_mode), .dp_width_sel(dp_width_sel),
    .dp_data_in(dp_data_in), .dp_data_out(dp_data_out), .key_idx(key_idx), .busy(busy)
  );

  aes_inv_round_ctrl #(.MSW_FIRST(0)) dut_lsw (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(b_in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .err(b_err),
    .dp_round(b_dp_round), .dp_mode(b_dp_mode), .dp_width_sel(b_dp_width_sel),
    .dp_data_in(b_dp_data_in), .dp_data_out(b_dp_data_out), .key_idx(b_key_idx), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AES arithmetic and key store ----------------
  logic [7:0]   sb  [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] rk  [0:2][0:14];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic expand(input int m);
    int nk = 4 + 2 * m;
    int nr = nk + 6;
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k <= nr; k++) rk[m][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // One inverse round as the datapath computes it: key add, optional InvMixColumns,
  // then InvShiftRows/InvSubBytes; the round numbered Nr is the key add alone.
  function automatic logic [127:0] dp_fn(input logic [127:0] s, input logic [3:0] rnd,
                                         input logic [1:0] md, input logic [3:0] ki);
    int nrb = 10 + 2 * int'(md);
    logic [127:0] k = (md != 2'b11 && ki <= 4'd14) ? rk[md][ki] : '0;
    logic [127:0] t = s ^ k;
    logic [127:0] u = '0;
    logic [7:0] a0, a1, a2, a3;
    if (int'(rnd) == nrb) return t;
    if (rnd != 4'd0) begin
      for (int c = 0; c < 4; c++) begin
        a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
        u[127-8*(4*c)   -: 8] = gm(a0,8'h0e)^gm(a1,8'h0b)^gm(a2,8'h0d)^gm(a3,8'h09);
        u[127-8*(4*c+1) -: 8] = gm(a0,8'h09)^gm(a1,8'h0e)^gm(a2,8'h0b)^gm(a3,8'h0d);
        u[127-8*(4*c+2) -: 8] = gm(a0,8'h0d)^gm(a1,8'h09)^gm(a2,8'h0e)^gm(a3,8'h0b);
        u[127-8*(4*c+3) -: 8] = gm(a0,8'h0b)^gm(a1,8'h0d)^gm(a2,8'h09)^gm(a3,8'h0e);
      end
      t = u;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        u[127-8*(4*c+r) -: 8] = isb[gb(t, 4*(((c - r) + 4) % 4) + r)];
    return u;
  endfunction

  always @(negedge clk) begin
    dp_data_out   = dp_fn(dp_data_in, dp_round, dp_mode, key_idx);
    b_dp_data_out = dp_fn(b_dp_data_in, b_dp_round, b_dp_mode, b_key_idx);
  end

  // ---------------- transaction model ----------------
  int         cyc = 0;
  int         m_t0 = 0;
  int         m_nr = 10;
  logic [1:0] m_mode = 2'b00;
  logic       m_active = 1'b0;
  logic       m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_err    = 1'b0;
      cyc      = 0;
      m_t0     = 0;
    end else begin
      logic abort_now;
      abort_now = 1'b0;
`ifdef AES_INV_CTRL_ABORT_EN
      abort_now = abort;
`endif
      m_err = 1'b0;
      if (m_active) begin
        if (abort_now) m_active = 1'b0;
        else if ((cyc - m_t0) >= 5 * m_nr + 1 && out_ready) m_active = 1'b0;
      end else if (in_valid) begin
        if (in_mode == 2'b11) m_err = 1'b1;
        else begin
          m_active = 1'b1;
          m_t0     = cyc + 1;
          m_nr     = 10 + 2 * int'(in_mode);
          m_mode   = in_mode;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    int rel, r, p;
    logic ov;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_dp_round", dp_round, 0);
      chk("rst_dp_mode", dp_mode, 0);
      chk("rst_width_sel", dp_width_sel, 0);
      chk("rst_key_idx", key_idx, 0);
      chk("rst_dp_data_in", dp_data_in, 0);
      chk("rst_lsw_width_sel", b_dp_width_sel, 0);
    end else begin
      rel = cyc - m_t0;
      ov  = m_active && rel >= 5 * m_nr + 1;
      chk("in_ready", in_ready, !m_active);
      chk("busy", busy, m_active);
      chk("err", err, m_err);
      chk("out_valid", out_valid, ov);
      chk("lsw_out_valid", b_out_valid, ov);
      if (ov) begin
        chk("out_data", out_data, PT);
        chk("lsw_out_data", b_out_data, PT);
      end
      if (m_active) begin
        chk("dp_mode", dp_mode, m_mode);
        if (rel < 5 * m_nr) begin
          r = rel / 5;
          p = rel % 5;
          chk("dp_round", dp_round, r);
          chk("key_idx", key_idx, m_nr - r);
          chk("width_sel", dp_width_sel, (p < 4) ? 3 - p : 0);
          chk("lsw_width_sel", b_dp_width_sel, (p < 4) ? p : 3);
        end else if (rel == 5 * m_nr) begin
          chk("last_dp_round", dp_round, m_nr);
          chk("last_key_idx", key_idx, 0);
          chk("last_width_sel", dp_width_sel, 0);
          chk("lsw_last_width_sel", b_dp_width_sel, 3);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] m, input logic [127:0] d, output int waits);
    logic hs = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    waits    = 0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    chk("send_handshake", hs, 1);
    in_valid = 1'b0;
    in_mode  = 2'b11;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input int exp_lat, input string name);
    int n = 1;
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_plaintext"}, out_data, PT);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, errs, busy_seen, ov_seen;
    #1 rst_n = 1'b0;
    build_tables();
    for (int m = 0; m < 3; m++) expand(m);
    chk("sbox_53", sb[8'h53], 8'hed);
    chk("key128_last", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(2'b00, CT128, w);
    wait_out(52, "aes128");
    send(2'b01, CT192, w);
    wait_out(62, "aes192");
    send(2'b10, CT256, w);
    wait_out(72, "aes256");

    // Backpressure with a second request waiting.
    out_ready = 1'b0;
    send(2'b00, CT128, w);
    wait_out(52, "bp_first");
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = CT192;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold", out_data, PT);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b01, CT192, w);
    chk("bp_accept_delay", w, 2);
    wait_out(62, "bp_second");

    // Illegal mode is swallowed with a single err pulse.
    send(2'b11, CT128, w);
    chk("illegal_accept_delay", w, 1);
    errs = 0; busy_seen = 0; ov_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      errs += int'(err);
      busy_seen += int'(busy);
      ov_seen += int'(out_valid);
      @(posedge clk);
      #1;
    end
    chk("illegal_err_count", errs, 1);
    chk("illegal_busy", busy_seen, 0);
    chk("illegal_out_valid", ov_seen, 0);
    send(2'b10, CT256, w);
    wait_out(72, "after_illegal");

    // Asynchronous reset in round 5.
    send(2'b00, CT128, w);
    repeat (26) @(posedge clk);
    #1;
    chk("pre_reset_round", dp_round, 5);
    rst_n = 1'b0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_in_ready", in_ready, 1);
    chk("areset_dp_round", dp_round, 0);
    chk("areset_key_idx", key_idx, 0);
    chk("areset_dp_data_in", dp_data_in, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'b00, CT128, w);
    wait_out(52, "after_reset");

`ifdef AES_INV_CTRL_ABORT_EN
    send(2'b01, CT192, w);
    repeat (20) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_err", err, 0);
    out_ready = 1'b0;
    send(2'b00, CT128, w);
    wait_out(52, "abort_done_run");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    out_ready = 1'b1;
    chk("abort_done_out_valid", out_valid, 0);
    chk("abort_done_busy", busy, 0);
    send(2'b10, CT256, w);
    wait_out(72, "after_abort");
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
